// File: rtl/ring_johnson_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ring_johnson_cnt
// Brief    : Ring and Johnson shift-register counters sharing one parallel
//            load port. Optional macro CNT_SELF_CORRECT_EN recovers illegal
//            states in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ring_johnson_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic             q1_valid,
    output logic             q2_valid
);

    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    logic [WIDTH-1:0] ring_q, ring_d;
    logic [WIDTH-1:0] john_q, john_d;
    logic [WIDTH-1:0] john_inv;

    assign john_inv = ~john_q;

    // x & (x+1) == 0 holds exactly for the 0...01...1 codes (incl. all-zero/all-one)
    assign q1_valid = (ring_q != C_ZERO) && ((ring_q & (ring_q - C_ONE)) == C_ZERO);
    assign q2_valid = ((john_q & (john_q + C_ONE)) == C_ZERO) ||
                      ((john_inv & (john_inv + C_ONE)) == C_ZERO);

    always_comb begin
        ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
        john_d = {john_q[WIDTH-2:0], ~john_q[WIDTH-1]};
`ifdef CNT_SELF_CORRECT_EN
        if (!q1_valid) begin
            ring_d = C_ONE;
        end
        if (!q2_valid) begin
            john_d = C_ZERO;
        end
`endif
        if (ld) begin
            ring_d = d;
            john_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= C_ONE;
            john_q <= C_ZERO;
        end else begin
            ring_q <= ring_d;
            john_q <= john_d;
        end
    end

    assign q1 = ring_q;
    assign q2 = john_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_johnson_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_johnson_cnt
// Brief    : Directed self-checking bench for ring_johnson_cnt (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_johnson_cnt;

    logic       clk;
    logic       rst_n;
    logic       ld;
    logic [7:0] d;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       q1_valid;
    logic       q2_valid;

    int n_vec;
    int n_err;

    ring_johnson_cnt #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .d        (d),
        .q1       (q1),
        .q2       (q2),
        .q1_valid (q1_valid),
        .q2_valid (q2_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld    = 1'b1;
        d     = 8'hA5;
        repeat (2) step();
        n_vec++;
        if (q1 !== 8'h01 || q2 !== 8'h00 || q1_valid !== 1'b1 || q2_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_dominates_ld: got q1=%h q2=%h v1=%b v2=%b want 01 00 1 1",
                     q1, q2, q1_valid, q2_valid);
        end
        rst_n = 1'b1;
        d     = 8'h3C;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (q1 !== 8'h01 || q2 !== 8'h00 || q1_valid !== 1'b1 || q2_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got q1=%h q2=%h v1=%b v2=%b want 01 00 1 1",
                     q1, q2, q1_valid, q2_valid);
        end
        ld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_run();
        logic [7:0] john_exp [18];
        john_exp = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC,
                     8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01, 8'h03, 8'h07};
        ld = 1'b1;
        d  = 8'h01;
        step();
        ld = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            logic [7:0] ring_exp;
            ring_exp = 8'h01 << (k % 8);
            step();
            n_vec++;
            if (q1 !== ring_exp || q2 !== john_exp[k-1] || q1_valid !== 1'b1 || q2_valid !== 1'b1) begin
                n_err++;
                $display("FAIL load_run step %0d: got q1=%h q2=%h v1=%b v2=%b want %h %h 1 1",
                         k, q1, q2, q1_valid, q2_valid, ring_exp, john_exp[k-1]);
            end
        end
    endtask

    task automatic test_load_priority();
        ld = 1'b1;
        d  = 8'h10;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (q1 !== 8'h10 || q2 !== 8'h10) begin
                n_err++;
                $display("FAIL load_hold edge %0d: got q1=%h q2=%h want 10 10", k, q1, q2);
            end
        end
        ld = 1'b0;
        step();
        n_vec++;
        if (q1 !== 8'h20 || q2 !== 8'h21) begin
            n_err++;
            $display("FAIL load_release: got q1=%h q2=%h want 20 21", q1, q2);
        end
    endtask

    task automatic test_illegal_load();
        ld = 1'b1;
        d  = 8'h05;
        step();
        ld = 1'b0;
        n_vec++;
        if (q1 !== 8'h05 || q2 !== 8'h05 || q1_valid !== 1'b0 || q2_valid !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_load: got q1=%h q2=%h v1=%b v2=%b want 05 05 0 0",
                     q1, q2, q1_valid, q2_valid);
        end
        step();
        n_vec++;
`ifdef CNT_SELF_CORRECT_EN
        if (q1 !== 8'h01 || q2 !== 8'h00 || q1_valid !== 1'b1 || q2_valid !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_recover: got q1=%h q2=%h v1=%b v2=%b want 01 00 1 1",
                     q1, q2, q1_valid, q2_valid);
        end
`else
        if (q1 !== 8'h0A || q2 !== 8'h0B || q1_valid !== 1'b0 || q2_valid !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_persist: got q1=%h q2=%h v1=%b v2=%b want 0a 0b 0 0",
                     q1, q2, q1_valid, q2_valid);
        end
`endif
    endtask

    task automatic test_reset_mid_count();
        ld = 1'b1;
        d  = 8'h01;
        step();
        ld = 1'b0;
        repeat (5) step();
        n_vec++;
        if (q1 !== 8'h20 || q2 !== 8'h3F) begin
            n_err++;
            $display("FAIL mid_count: got q1=%h q2=%h want 20 3f", q1, q2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (q1 !== 8'h01 || q2 !== 8'h00 || q1_valid !== 1'b1 || q2_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got q1=%h q2=%h v1=%b v2=%b want 01 00 1 1",
                     q1, q2, q1_valid, q2_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_vec++;
        if (q1 !== 8'h02 || q2 !== 8'h01) begin
            n_err++;
            $display("FAIL after_reset_step: got q1=%h q2=%h want 02 01", q1, q2);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ld    = 1'b0;
        d     = 8'h00;
        test_reset();
        test_load_run();
        test_load_priority();
        test_illegal_load();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_johnson_cnt.md
# ring_johnson_cnt

Dual 8-bit shift-register counter block: a ring counter and a Johnson (twisted-ring) counter share one clock, reset and parallel-load port. Both counters load the same `d` value and then advance once per clock. The block is a sequencing/phase-generation primitive for timing-strobe and one-hot state-decode logic.

## Interface
Parameters:
- `WIDTH`, default 8: register width of both counters; must be ≥ 2.

Ports:
- `clk`  input  1  rising-edge clock; one clock, all state in this domain.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `ld`  input  1  synchronous parallel load into both counters.
- `d`  input  WIDTH  load value.
- `q1`  output  WIDTH  ring counter state (registered).
- `q2`  output  WIDTH  Johnson counter state (registered).
- `q1_valid`  output  1  combinational; high when `q1` is exactly one-hot.
- `q2_valid`  output  1  combinational; high when `q2` is a legal Johnson code.

## Operation
- Ring counter, per rising `clk`:
  - `ld`=1: `q1 <= d`.
  - else: rotate left, `q1 <= {q1[WIDTH-2:0], q1[WIDTH-1]}`.
- Johnson counter, per rising `clk`:
  - `ld`=1: `q2 <= d`.
  - else: `q2 <= {q2[WIDTH-2:0], ~q2[WIDTH-1]}`.
- `ld` has priority over counting; no enable: counters advance every clock.
- Any `d` value is accepted, including illegal codes. Without self-correction, illegal patterns circulate unchanged in shape: ring period WIDTH, Johnson period 2·WIDTH or a divisor of it.
- Sequences, WIDTH=8:
  - Ring from 00000001: 00000010, 00000100, … 10000000, 00000001; period 8.
  - Johnson from 00000001: 00000011, 00000111, … 11111111, 11111110, … 10000000, 00000000, 00000001; period 16.
- `q1_valid`: popcount(`q1`)==1.
- `q2_valid`: `q2` is one of the 2·WIDTH codes of the form 0…01…1 or 1…10…0. This includes all-zero and all-one.

## Timing
- Reset (`rst_n`=0), asynchronous, independent of `clk`:
  - `q1` = 0…01.
  - `q2` = 0…0.
  - `q1_valid`=1, `q2_valid`=1.
- Reset dominates `ld`. Counting resumes on the first rising edge after `rst_n` deasserts.
- Load latency: 1 cycle; `q` shows `d` after the edge that samples `ld`=1.
- Each non-load edge advances exactly one step.
- `ld` held high for N edges reloads `d` each edge; counting starts on the first edge with `ld`=0.
- Valid flags track `q` combinationally with zero latency.
- Mid-operation reset forces reset values immediately; the next edge after release steps from the reset values.

## Configuration
- `CNT_SELF_CORRECT_EN` defined:
  - On a non-load edge where `q1_valid`=0, next `q1` = 0…01.
  - On a non-load edge where `q2_valid`=0, next `q2` = 0…0.
  - Illegal states therefore recover in one cycle. Loads are not filtered: an illegal `d` still loads and is corrected on the following edge.
- `CNT_SELF_CORRECT_EN` undefined: pure rotate/twist as specified; illegal states persist.

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-cycle -> immediately `q1`=00000001, `q2`=00000000, both valid flags 1.
- Load-and-run: `ld`=1, `d`=00000001 for one edge, then `ld`=0 for 18 edges -> `q1` rotates with period 8; `q2` follows 00000011…11111111…00000000, 00000001 with period 16.
- Load priority: `ld`=1 held for 3 edges with `d`=00010000 -> both `q` hold 00010000; first non-load edge gives `q1`=00100000, `q2`=00100001.
- Illegal load, macro off: `d`=00000101 -> `q1`=00001010 after 1 edge, `q1_valid`=0 throughout; `q2_valid`=0.
- Illegal load, `CNT_SELF_CORRECT_EN` on: `d`=00000101 -> after 1 non-load edge `q1`=00000001, `q2`=00000000, both valid flags 1.
- Reset mid-count: after 5 count edges, pulse `rst_n` low -> reset values; first edge after release gives `q1`=00000010, `q2`=00000001.
